// File: rtl/mau_pkg.sv
// Shared types and constants for the memory access unit: FSM states,
// request size encodings, byte-lane geometry and the latched request record.
package mau_pkg;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;
    localparam int DATA_W    = NUM_LANES * LANE_W;

    typedef struct packed {
        logic              write;
        logic [1:0]        size;
        logic              sign;
        logic [1:0]        off;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // Reserved size behaves as a full word when it is not rejected.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == SZ_RSV) ? SZ_W : size;
    endfunction

    // Lane offset with the low address bits masked to the access alignment.
    function automatic logic [1:0] lane_off(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_B:    return addr_lo;
            SZ_H:    return {addr_lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mau_if.sv
// Request/response handshake and word-memory bus of the memory access unit.
// slave = the unit itself, master = requester plus memory.
interface mau_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mau_lane_unit.sv
// Combinational lane logic: byte enables, sub-word store merge into the
// read word, and little-endian load extraction with optional sign extension.
module mau_lane_unit
    import mau_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        off,
    input  logic              sign,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] merged,
    output logic [DATA_W-1:0] load
);
    logic [NUM_LANES-1:0]             be;
    logic [NUM_LANES-1:0][LANE_W-1:0] wrep;
    logic [NUM_LANES-1:0][LANE_W-1:0] rword;
    logic [NUM_LANES-1:0][LANE_W-1:0] mword;
    logic [DATA_W-1:0]                shifted;

    // Store data is replicated across lanes so each lane just picks its own byte.
    always_comb begin
        be   = '1;
        wrep = wdata;
        case (size)
            SZ_B: begin
                be   = NUM_LANES'(1) << off;
                wrep = {NUM_LANES{wdata[7:0]}};
            end
            SZ_H: begin
                be   = off[1] ? NUM_LANES'(4'b1100) : NUM_LANES'(4'b0011);
                wrep = {2{wdata[15:0]}};
            end
            default: be = '1;
        endcase
    end

    assign rword = rdata;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign mword[i] = be[i] ? wrep[i] : rword[i];
    end

    assign merged  = mword;
    assign shifted = rdata >> {off, 3'b000};

    always_comb begin
        load = shifted;
        case (size)
            SZ_B:    load = {{24{sign & shifted[7]}}, shifted[7:0]};
            SZ_H:    load = {{16{sign & shifted[15]}}, shifted[15:0]};
            default: load = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store initiator in front of a word memory; sub-word
// stores are read-modify-write. MAU_ALIGN_CHECK_EN enables request rejection.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 32
) (
    input logic clk,
    input logic reset,
    mau_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            state;
    req_t              req_q;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;
    logic [31:0]       mem_wdata;
    logic [ADDR_W-1:0] mem_addr;

    logic [1:0]        size_n;
    logic [1:0]        off_n;
    logic [ADDR_W-1:0] idx_n;
    logic              err_n;
    logic [31:0]       merged;
    logic [31:0]       load;
    logic              unused_addr_hi;

    assign size_n = norm_size(bus.req_size);
    assign off_n  = lane_off(size_n, bus.req_addr[1:0]);
    assign idx_n  = {{(ADDR_W-IDX_W){1'b0}}, bus.req_addr[2 +: IDX_W]};
    assign unused_addr_hi = ^bus.req_addr;

`ifdef MAU_ALIGN_CHECK_EN
    assign err_n = (bus.req_size == SZ_RSV)
                || (bus.req_size == SZ_H && bus.req_addr[0])
                || (bus.req_size == SZ_W && bus.req_addr[1:0] != 2'b00)
                || (bus.req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH));
`else
    assign err_n = 1'b0;
`endif

    mau_lane_unit u_lane (
        .size   (req_q.size),
        .off    (req_q.off),
        .sign   (req_q.sign),
        .wdata  (req_q.wdata),
        .rdata  (bus.mem_rdata),
        .merged (merged),
        .load   (load)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_q      <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    req_q <= '{write: bus.req_write, size: size_n, sign: bus.req_signed,
                               off: off_n, wdata: bus.req_wdata};
                    if (err_n) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        state      <= RESP;
                    end else begin
                        resp_err <= 1'b0;
                        mem_addr <= idx_n;
                        // Full-word stores skip the read; the data goes out unmodified.
                        if (bus.req_write && size_n == SZ_W) begin
                            mem_wdata <= bus.req_wdata;
                            state     <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (req_q.write) begin
                        mem_wdata <= merged;
                        state     <= WR;
                    end else begin
                        resp_rdata <= load;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                WR: begin
                    resp_rdata <= '0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: if (bus.resp_ready) begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = resp_valid;
    assign bus.resp_err   = resp_err;
    assign bus.resp_rdata = resp_rdata;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.mem_we     = (state == WR) && !reset;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level model predicts each
// cycle's handshake/memory activity and one negedge process compares it.
module tb_mem_access_unit;
    localparam int DEPTH = 32;
    localparam int IW    = 5;

    typedef struct packed {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
    } rq_t;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        logic [31:0] nw;
        int          idx;
        int          nph;
    } mx_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mau_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [DEPTH];
    logic [31:0] mdl [DEPTH];
    bit          init_en = 1'b1;

    function automatic logic [31:0] init_word(input int i);
        return (i == 1) ? 32'h11223344 : ((32'h01010101 * 32'(i)) ^ 32'hA5000000);
    endfunction

    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[IW-1:0]] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = mem[bus.mem_addr[IW-1:0]];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    bit          chk_en = 1'b0;
    bit          exp_ready, exp_valid, exp_we, exp_acc, exp_err;
    logic [31:0] exp_rdata, exp_addr, exp_wdata;
    logic [31:0] last_rdata;
    logic        last_err;

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
            check("resp_valid", 32'(bus.resp_valid), 32'(exp_valid));
            check("mem_we", 32'(bus.mem_we), 32'(exp_we));
            if (exp_valid) begin
                check("resp_rdata", bus.resp_rdata, exp_rdata);
                check("resp_err", 32'(bus.resp_err), 32'(exp_err));
            end
            if (exp_acc) check("mem_addr", bus.mem_addr, exp_addr);
            if (exp_we) check("mem_wdata", bus.mem_wdata, exp_wdata);
        end
    end

    // Model: arithmetic on the byte address and the model memory.
    function automatic mx_t model(input rq_t r);
        mx_t         m;
        int          sz, nb, off;
        logic [63:0] lmask, val;
        logic [31:0] old;
        m  = '0;
        sz = int'(r.sz);
`ifdef MAU_ALIGN_CHECK_EN
        m.err = (sz == 3) || (sz == 1 && r.a[0]) || (sz == 2 && r.a[1:0] != 2'b00)
             || ((r.a >> 2) >= 32'(DEPTH));
        m.idx = int'(r.a >> 2);
`else
        if (sz == 3) sz = 2;
        m.idx = int'((r.a >> 2) % 32'(DEPTH));
`endif
        if (m.err) return m;
        nb    = 1 << sz;
        off   = (int'(r.a % 4) / nb) * nb;
        old   = mdl[m.idx];
        lmask = (64'd1 << (8 * nb)) - 64'd1;
        val   = ({32'b0, old} >> (8 * off)) & lmask;
        if (r.sg && nb < 4 && val[8*nb-1]) val = val | ~lmask;
        m.nw    = 32'(({32'b0, old} & ~(lmask << (8 * off))) | (({32'b0, r.wd} & lmask) << (8 * off)));
        m.rdata = r.w ? 32'h0 : val[31:0];
        m.nph   = (r.w && nb < 4) ? 2 : 1;
        return m;
    endfunction

    function automatic rq_t mk(input logic w, input logic [1:0] sz, input logic sg,
                               input logic [31:0] a, input logic [31:0] wd);
        rq_t r;
        r.w = w; r.sz = sz; r.sg = sg; r.a = a; r.wd = wd;
        return r;
    endfunction

    task automatic drive(input rq_t r);
        bus.req_write  = r.w;
        bus.req_size   = r.sz;
        bus.req_signed = r.sg;
        bus.req_addr   = r.a;
        bus.req_wdata  = r.wd;
        bus.req_valid  = 1'b1;
    endtask

    task automatic issue(input rq_t r, input int stall, input bit rst_wr, input bit has_nxt, input rq_t nxt);
        mx_t m;
        bit  is_wr;
        m = model(r);
        drive(r);
        exp_ready = 1; exp_valid = 0; exp_we = 0; exp_acc = 0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int p = 0; p < m.nph; p++) begin
            is_wr     = r.w && (p == m.nph - 1);
            exp_ready = 0; exp_acc = 1; exp_addr = 32'(m.idx);
            exp_we    = is_wr; exp_wdata = m.nw;
            if (is_wr && rst_wr) begin
                reset  = 1'b1;
                exp_we = 0;
            end
            @(posedge clk); #1;
            if (is_wr && rst_wr) begin
                reset = 1'b0; exp_acc = 0; exp_ready = 1;
                return;
            end
            if (is_wr) mdl[m.idx] = m.nw;
        end
        exp_acc = 0; exp_we = 0; exp_valid = 1; exp_ready = 0;
        exp_rdata = m.rdata; exp_err = m.err;
        if (has_nxt) drive(nxt);
        repeat (stall) begin @(posedge clk); #1; end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        last_rdata = bus.resp_rdata;
        last_err   = bus.resp_err;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        exp_valid = 0; exp_ready = 1;
    endtask

    rq_t none;

    initial begin
        none           = '0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = init_word(i);
        repeat (3) @(posedge clk);
        #1;
        init_en = 1'b0;
        reset   = 1'b0;

        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        exp_ready = 1; exp_valid = 0; exp_we = 0; exp_acc = 0; exp_err = 0;
        chk_en = 1'b1;

        issue(mk(1, 2'b10, 0, 32'h08, 32'hDEADBEEF), 0, 0, 0, none);
        check("sw_mem2", mem[2], 32'hDEADBEEF);
        issue(mk(0, 2'b10, 0, 32'h08, 32'h0), 0, 0, 0, none);
        check("lw_08", last_rdata, 32'hDEADBEEF);

        issue(mk(1, 2'b00, 0, 32'h06, 32'h000000AA), 0, 0, 0, none);
        check("sb_mem1", mem[1], 32'h11AA3344);
        issue(mk(0, 2'b00, 1, 32'h06, 32'h0), 0, 0, 0, none);
        check("lb_06", last_rdata, 32'hFFFFFFAA);
        issue(mk(0, 2'b00, 0, 32'h06, 32'h0), 0, 0, 0, none);
        check("lbu_06", last_rdata, 32'h000000AA);
        issue(mk(0, 2'b01, 1, 32'h04, 32'h0), 0, 0, 0, none);
        check("lh_04", last_rdata, 32'h00003344);

        issue(mk(0, 2'b10, 0, 32'h0A, 32'h0), 0, 0, 0, none);
`ifdef MAU_ALIGN_CHECK_EN
        check("lw_0a_err", 32'(last_err), 32'd1);
`else
        check("lw_0a", last_rdata, 32'hDEADBEEF);
`endif

        issue(mk(1, 2'b01, 0, 32'h0E, 32'hCAFE1234), 0, 0, 0, none);
        issue(mk(0, 2'b01, 1, 32'h0E, 32'h0), 0, 0, 0, none);
        check("lh_0e", last_rdata, 32'h00001234);
        issue(mk(1, 2'b00, 0, 32'h0D, 32'h00000080), 0, 0, 0, none);
        issue(mk(0, 2'b00, 1, 32'h0D, 32'h0), 0, 0, 0, none);
        check("lb_0d", last_rdata, 32'hFFFFFF80);

        issue(mk(0, 2'b11, 0, 32'h08, 32'h0), 0, 0, 0, none);
        issue(mk(0, 2'b10, 0, 32'h84, 32'h0), 0, 0, 0, none);
`ifdef MAU_ALIGN_CHECK_EN
        check("lw_84_err", 32'(last_err), 32'd1);
`else
        check("lw_84_wrap", last_rdata, 32'h11AA3344);
`endif

        // Back-pressure: a second request waits through the stalled response.
        issue(mk(0, 2'b10, 0, 32'h08, 32'h0), 3, 0, 1, mk(0, 2'b00, 0, 32'h06, 32'h0));
        check("stall_lw", last_rdata, 32'hDEADBEEF);
        issue(mk(0, 2'b00, 0, 32'h06, 32'h0), 0, 0, 0, none);
        check("after_stall_lbu", last_rdata, 32'h000000AA);

        issue(mk(1, 2'b00, 0, 32'h06, 32'h00000055), 0, 1, 0, none);
        @(negedge clk);
        check("rstwr_mem1", mem[1], 32'h11AA3344);
        check("rstwr_mem_addr", bus.mem_addr, 32'd0);
        check("rstwr_mem_wdata", bus.mem_wdata, 32'd0);
        issue(mk(0, 2'b00, 0, 32'h06, 32'h0), 0, 0, 0, none);
        check("post_rst_lbu", last_rdata, 32'h000000AA);

        chk_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) check($sformatf("mem_final[%0d]", i), mem[i], mdl[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that sits between the CPU datapath and the word-addressed data memory (32-bit `Addr`/`writeData`/`readData`, write-enable, combinational read, write on `posedge clk`). It accepts byte-addressed load/store requests over a valid/ready handshake and converts them to word accesses. Sub-word stores are performed as read-modify-write. Loads return zero- or sign-extended data over a valid/ready response handshake.

## Interface
- `DEPTH`, 32: memory size in 32-bit words; word index range 0..DEPTH-1.
- `ADDR_W`, 32: width of request and memory address buses.
- `clk` in 1: single clock, all state on posedge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; equals (state==IDLE).
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_signed` in 1: sign-extend load result.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: response present; held until accepted.
- `resp_ready` in 1: response consumer ready.
- `resp_rdata` out 32: extended load data; 0 for stores.
- `resp_err` out 1: request rejected, no memory access made.
- `mem_addr` out ADDR_W: word index to memory, `{2'b0, addr[ADDR_W-1:2]}`.
- `mem_wdata` out 32: merged write word.
- `mem_we` out 1: memory write enable.
- `mem_rdata` in 32: memory read data (combinational).

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE: on `req_valid && req_ready`, latch all request fields, then transition:
  - load → RD
  - word store → WR
  - sub-word store → RD
  - error → RESP with err set
- RD: drive `mem_addr`, capture `mem_rdata` into the data register.
  - Load: extract the lane and extend, then go to RESP.
  - Sub-word store: merge the store data into the captured word, then go to WR.
- WR: `mem_we = 1` for exactly one cycle with `mem_wdata` = merged word, or `req_wdata` for a word store. Then go to RESP.
- RESP: `resp_valid = 1`. On `resp_ready`, go to IDLE. `resp_rdata` and `resp_err` are stable while `resp_valid` is high.
- Lanes are little-endian.
  - Byte lane = `addr[1:0]`.
  - Half lane = `addr[1]`.
  - Byte/half store overwrites only the selected bytes of the word.
  - Load extension: `req_signed` replicates bit 7/15 into the upper bits, otherwise the upper bits are zero-filled.
- `mem_we = (state==WR) && !reset`. Asserting `reset` in the WR cycle suppresses that write.
- `mem_addr` holds its last value outside RD/WR.
- Reset values:
  - state = IDLE, so `req_ready` = 1.
  - `resp_valid`, `resp_err`, `mem_we` = 0.
  - `resp_rdata`, `mem_addr`, `mem_wdata` = 0.
- Reset mid-operation: the request is abandoned and no response is issued.

## Timing
Request accepted at edge T:
- Error: `resp_valid` at T+1.
- Load and word store: `resp_valid` at T+2.
- Sub-word store: `resp_valid` at T+3; memory updated at the edge closing the WR cycle.

Throughput and back-to-back behaviour:
- At most one outstanding request; `req_ready` is low from T until the RESP handshake completes.
- A new request may be accepted in the cycle after the RESP handshake.
- `req_valid` while `req_ready` is low is ignored; the requester must hold it.

## Configuration
`MAU_ALIGN_CHECK_EN` defined:
- `resp_err` = 1, with no RD/WR cycles, for any of:
  - misaligned half (`addr[0]`)
  - misaligned word (`addr[1:0]!=0`)
  - `req_size==11`
  - word index ≥ DEPTH

Undefined:
- `resp_err` is tied to 0.
- Low address bits are masked to the size alignment.
- Size 11 is treated as word.
- Index is taken modulo DEPTH (upper index bits zeroed to `$clog2(DEPTH)`).

## Structure
- Package `mau_pkg`:
  - state enum (IDLE/RD/WR/RESP)
  - size encodings `SZ_B`, `SZ_H`, `SZ_W`, `SZ_RSV`
  - lane helper constants
- Sub-module `mau_lane_unit`, combinational:
  - byte-enable generation
  - store merge
  - load extraction/extension
- The FSM stays in `mem_access_unit`.

## Test plan
- Word store 0xDEADBEEF at addr 0x08, then word load at 0x08 → write to index 2 at T+1; load `resp_rdata` = 0xDEADBEEF at T+2.
- With word 0x11223344 at index 1, byte store 0xAA at addr 0x06 → RD then WR; memory word = 0x11AA3344; resp at T+3.
- Same word, signed byte load at 0x06 after the above → 0xFFFFFFAA; unsigned → 0x000000AA; signed half at 0x04 → 0x00003344.
- Misaligned word load at 0x0A:
  - with the macro: `resp_err` = 1 at T+1, `mem_we` never high.
  - without the macro: reads index 2.
- `resp_ready` held low 3 cycles during RESP → `resp_valid`/`resp_rdata` stable, `req_ready` = 0, second request not accepted until the cycle after the handshake.
- `reset` asserted during the WR cycle of a byte store → memory unchanged, next cycle `req_ready` = 1, `resp_valid` = 0.
